// File: rtl/inta_sequencer.sv
// 8259A INTA sequencer: masks and prioritises IRR requests, raises INT, runs the two-pulse
// 8086 acknowledge handshake, maintains the ISR and drives the interrupt vector.

module inta_sequencer_chk (
    input logic       clk,
    input logic       resetN,
    input logic       INT,
    input logic       dataOutEnable,
    input logic [7:0] clearRequest,
    input logic [7:0] inServiceRegister
);

    a_clear_onehot : assert property (@(posedge clk) disable iff (!resetN)
        $onehot0(clearRequest));

    a_clear_in_isr : assert property (@(posedge clk) disable iff (!resetN)
        (clearRequest & ~inServiceRegister) == 8'h00);

    a_int_not_during_vector : assert property (@(posedge clk) disable iff (!resetN)
        !(INT && dataOutEnable));

endmodule

module inta_sequencer #(
    parameter int INTA_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] interruptRequest,
    input  logic [7:0] interruptMask,
    input  logic [4:0] vectorBase,
    input  logic       autoEOI,
    input  logic       nonSpecificEOI,
    input  logic       specificEOI,
    input  logic [2:0] eoiLevel,
    input  logic       interruptAcknowledgeN,
    output logic       INT,
    output logic [7:0] dataOut,
    output logic       dataOutEnable,
    output logic [7:0] inServiceRegister,
    output logic [7:0] clearRequest
);

    localparam int                CNT_W    = $clog2(INTA_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INTA_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ACK1  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_ACK2  = 3'd4
    } state_t;

    // Returns {found, index} of the lowest set bit (IR0 is the highest priority).
    function automatic logic [3:0] lowest_one(input logic [7:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            r = v[i] ? {1'b1, 3'(i)} : r;
        end
        return r;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    // Levels strictly above every in-service level (fully nested mode).
    function automatic logic [7:0] priority_window(input logic [7:0] isr);
        logic [7:0] win;
        logic       blocked;
        win     = 8'h00;
        blocked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            blocked = blocked | isr[i];
            win[i]  = ~blocked;
        end
        return win;
    endfunction

    state_t           state_q, state_d;
    logic             int_q, int_d;
    logic [7:0]       dout_q, dout_d;
    logic             oe_q, oe_d;
    logic [7:0]       isr_q, isr_d;
    logic [7:0]       clr_q, clr_d;
    logic             prev_q;
    logic [2:0]       lvl_q, lvl_d;
    logic             spur_q, spur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fall_s, rise_s;
    logic [7:0]       cand_s;
    logic [3:0]       win_s;
    logic [3:0]       isr_low_s;
    logic [7:0]       eoi_clr_s;
    logic [7:0]       auto_clr_s;
    logic [7:0]       set_s;

    assign fall_s    = prev_q & ~interruptAcknowledgeN;
    assign rise_s    = ~prev_q & interruptAcknowledgeN;
    assign cand_s    = interruptRequest & ~interruptMask & priority_window(isr_q);
    assign win_s     = lowest_one(cand_s);
    assign isr_low_s = lowest_one(isr_q);

    // EOI clears act on the ISR as it stood before this cycle's set.
    always_comb begin
        eoi_clr_s = 8'h00;
        if (nonSpecificEOI && isr_low_s[3]) begin
            eoi_clr_s = eoi_clr_s | onehot8(isr_low_s[2:0]);
        end else begin
            eoi_clr_s = eoi_clr_s;
        end
        if (specificEOI) begin
            eoi_clr_s = eoi_clr_s | onehot8(eoiLevel);
        end else begin
            eoi_clr_s = eoi_clr_s;
        end
    end

    // Handshake FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        int_d      = int_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        lvl_d      = lvl_q;
        spur_d     = spur_q;
        cnt_d      = cnt_q;
        clr_d      = 8'h00;
        set_s      = 8'h00;
        auto_clr_s = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (win_s[3]) begin
                    state_d = ST_REQ;
                    int_d   = 1'b1;
                end else begin
                    int_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (fall_s) begin
                    state_d = ST_ACK1;
                    int_d   = 1'b0;
                    if (win_s[3]) begin
                        lvl_d  = win_s[2:0];
                        spur_d = 1'b0;
                        set_s  = onehot8(win_s[2:0]);
                        clr_d  = onehot8(win_s[2:0]);
                    end else begin
                        // Request vanished before the acknowledge: spurious IR7 vector.
                        lvl_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end else begin
                    int_d = 1'b1;
                end
            end
            ST_ACK1: begin
                if (rise_s) begin
                    state_d = ST_WAIT2;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_WAIT2: begin
                if (fall_s) begin
                    state_d = ST_ACK2;
                    dout_d  = {vectorBase, lvl_q};
                    oe_d    = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_ACK2: begin
                if (rise_s) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    dout_d  = 8'h00;
                    if (autoEOI && !spur_q) begin
                        auto_clr_s = onehot8(lvl_q);
                    end else begin
                        auto_clr_s = 8'h00;
                    end
                end else begin
                    oe_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                int_d   = 1'b0;
                oe_d    = 1'b0;
                dout_d  = 8'h00;
            end
        endcase

        // A set on the same bit as a clear wins.
        isr_d = (isr_q & ~(eoi_clr_s | auto_clr_s)) | set_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            int_q   <= 1'b0;
            dout_q  <= 8'h00;
            oe_q    <= 1'b0;
            isr_q   <= 8'h00;
            clr_q   <= 8'h00;
            prev_q  <= 1'b1;
            lvl_q   <= 3'd0;
            spur_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            isr_q   <= isr_d;
            clr_q   <= clr_d;
            prev_q  <= interruptAcknowledgeN;
            lvl_q   <= lvl_d;
            spur_q  <= spur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign INT               = int_q;
    assign dataOut           = dout_q;
    assign dataOutEnable     = oe_q;
    assign inServiceRegister = isr_q;
    assign clearRequest      = clr_q;

    inta_sequencer_chk u_chk (
        .clk               (clk),
        .resetN            (resetN),
        .INT               (int_q),
        .dataOutEnable     (oe_q),
        .clearRequest      (clr_q),
        .inServiceRegister (isr_q)
    );

endmodule
